// File: rtl/output_buffer_pkg.sv
// Shared definitions for the chronospatial pipeline output stage: value width,
// the REG_O destination select, and the output buffer state encodings.
package output_buffer_pkg;

    localparam int OUT_DATA_W = 3;

    // Destination select that marks an execute-stage write as a REG_O emission
    localparam logic [1:0] SEL_REG_O = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/output_buffer_mem.sv
// Storage array for the output buffer: synchronous write, asynchronous
// (show-ahead) read.
module out_buf_mem #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 3
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/output_buffer.sv
// Output FIFO between execute (REG_O writes) and the pins, with stall, halt/drain
// tracking and done. Optional sticky drop flag: define OUT_BUF_OVERFLOW_FLAG_EN.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = OUT_DATA_W,
    parameter int AF_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    input  logic                   prog_halt,
    output logic                   stall,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] STALL_TH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_count;
    buf_state_t    r_state;
    buf_state_t    w_nextState;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // The extra pointer bit distinguishes a full buffer from an empty one
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = in_valid && (!w_full || w_pop) && (r_state != ST_DONE);

    out_buf_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wrPtr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rdPtr[AW-1:0]),
        .o_rdata (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Leave DRAIN only when nothing is queued and nothing is arriving
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN: begin
                if (prog_halt) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty && !w_push && !in_valid) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_DONE;
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    assign out_valid = !w_empty;
    assign count     = r_count;
    assign stall     = (r_count >= STALL_TH);
    assign done      = (r_state == ST_DONE);

`ifdef OUT_BUF_OVERFLOW_FLAG_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = in_valid && w_full && !w_pop && (r_state != ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed vector table plus a
// pointer-wrap sequence checked against a small queue model.
module tb_output_buffer;

`ifdef OUT_BUF_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] in_data;
    logic       in_valid;
    logic       prog_halt;
    logic       stall;
    logic [2:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       done;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] d;
        logic       rdy;
        logic       halt;
        logic       ov;
        logic [2:0] od;
        logic [3:0] cnt;
        logic       st;
        logic       dn;
        logic       of;
    } vec_t;

    vec_t vecs[$];
    logic [2:0] model[$];

    output_buffer #(
        .DEPTH     (8),
        .DATA_W    (3),
        .AF_MARGIN (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .prog_halt (prog_halt),
        .stall     (stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic addVec(input logic r, input logic v, input logic [2:0] d, input logic rdy,
                          input logic halt, input logic ov, input logic [2:0] od,
                          input logic [3:0] cnt, input logic st, input logic dn, input logic of);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.rdy = rdy; t.halt = halt;
        t.ov = ov; t.od = od; t.cnt = cnt; t.st = st; t.dn = dn; t.of = of;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] d,
                                 input logic rdy, input logic halt);
        rst = r; in_valid = v; in_data = d; out_ready = rdy; prog_halt = halt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input logic ov, input logic [2:0] od,
                               input logic [3:0] cnt, input logic st, input logic dn, input logic of);
        chk("out_valid", idx, 32'(out_valid), 32'(ov));
        if (ov) chk("out_data", idx, 32'(out_data), 32'(od));
        chk("count", idx, 32'(count), 32'(cnt));
        chk("stall", idx, 32'(stall), 32'(st));
        chk("done", idx, 32'(done), 32'(dn));
        chk("overflow", idx, 32'(overflow), 32'(of));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; prog_halt = 1'b0;

        // Reset, then 5,2,7 streamed through with ready held high
        addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(0, 1, 5, 1, 0,  1, 5, 1, 0, 0, 0);
        addVec(0, 1, 2, 1, 0,  1, 2, 1, 0, 0, 0);
        addVec(0, 1, 7, 1, 0,  1, 7, 1, 0, 0, 0);
        addVec(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);

        // Six pushes with no consumer: stall at 6, falls at 5 on draining
        for (int k = 1; k <= 6; k++)
            addVec(0, 1, 3'(k), 0, 0,  1, 1, 4'(k), (k >= 6), 0, 0);
        for (int j = 1; j <= 6; j++)
            addVec(0, 0, 0, 1, 0,  (j < 6), 3'(j + 1), 4'(6 - j), 0, 0, 0);

        // Fill to 8, three drops, push+pop at full, then drain
        for (int k = 0; k < 8; k++)
            addVec(0, 1, 3'(k), 0, 0,  1, 0, 4'(k + 1), (k + 1 >= 6), 0, 0);
        addVec(0, 1, 1, 0, 0,  1, 0, 8, 1, 0, OVF_EN);
        addVec(0, 1, 2, 0, 0,  1, 0, 8, 1, 0, OVF_EN);
        addVec(0, 1, 3, 0, 0,  1, 0, 8, 1, 0, OVF_EN);
        addVec(0, 1, 5, 1, 0,  1, 1, 8, 1, 0, OVF_EN);
        for (int j = 1; j <= 8; j++)
            addVec(0, 0, 0, 1, 0,  (j < 8), (j <= 6) ? 3'(j + 1) : 3'd5, 4'(8 - j),
                   (8 - j >= 6), 0, OVF_EN);

        // Halt with three queued, one more push while draining, then done
        addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(0, 1, 4, 0, 0,  1, 4, 1, 0, 0, 0);
        addVec(0, 1, 1, 0, 0,  1, 4, 2, 0, 0, 0);
        addVec(0, 1, 6, 0, 0,  1, 4, 3, 0, 0, 0);
        addVec(0, 0, 0, 0, 1,  1, 4, 3, 0, 0, 0);
        addVec(0, 1, 3, 0, 1,  1, 4, 4, 0, 0, 0);
        addVec(0, 0, 0, 1, 1,  1, 1, 3, 0, 0, 0);
        addVec(0, 0, 0, 1, 1,  1, 6, 2, 0, 0, 0);
        addVec(0, 0, 0, 1, 1,  1, 3, 1, 0, 0, 0);
        addVec(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        addVec(0, 1, 2, 1, 1,  0, 0, 0, 0, 1, 0);
        addVec(0, 1, 5, 0, 1,  0, 0, 0, 0, 1, 0);

        // Reset while draining with four queued; afterwards back in RUN
        addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++)
            addVec(0, 1, 3'(k), 0, 0,  1, 1, 4'(k), 0, 0, 0);
        addVec(0, 0, 0, 0, 1,  1, 1, 4, 0, 0, 0);
        addVec(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(0, 1, 7, 0, 0,  1, 7, 1, 0, 0, 0);
        addVec(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].halt);
            checkOutput(i, vecs[i].ov, vecs[i].od, vecs[i].cnt, vecs[i].st, vecs[i].dn, vecs[i].of);
        end

        // Pointer wrap: 12 pushes with pops on alternate cycles, then drain
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput(1000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            logic       rdy;
            logic [2:0] d;
            rdy = 1'(i % 2);
            d   = 3'((i * 3 + 1) % 8);
            if (rdy && model.size() > 0) void'(model.pop_front());
            model.push_back(d);
            applyStimulus(0, 1, d, rdy, 0);
            checkOutput(1001 + i, 1, model[0], 4'(model.size()), (model.size() >= 6), 0, 0);
        end
        for (int i = 0; i < 12 && model.size() > 0; i++) begin
            void'(model.pop_front());
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput(1100 + i, (model.size() > 0), (model.size() > 0) ? model[0] : 3'd0,
                        4'(model.size()), (model.size() >= 6), 0, 0);
        end
        chk("wrap_drained", 1200, 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
# output_buffer

Downstream stage of the chronospatial pipeline: captures the 3-bit values emitted by the execute stage's output register (REG_O writes) into a small FIFO and presents them to the pins through a valid/ready handshake. Asserts a stall toward fetch/decode when nearly full so in-flight instructions are never lost. Tracks program halt and reports `done` once every emitted value has been drained.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `DATA_W`, 3: width of one output value.
- `AF_MARGIN`, 2: free entries reserved for instructions already in flight when `stall` rises.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_W  value written by execute (REG_O write).
- `in_valid`  in  1  one-cycle strobe per value; no backpressure on this side.
- `prog_halt`  in  1  level; program has halted.
- `stall`  out  1  to fetch/decode freeze input.
- `out_data`  out  DATA_W  head-of-FIFO value.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `done`  out  1  halt seen and FIFO drained.
- `overflow`  out  1  sticky drop flag (see Configuration).

## Operation
- Storage: DEPTH×DATA_W array; read/write pointers of $clog2(DEPTH)+1 bits (extra wrap bit); full = MSBs differ and low bits equal; empty = pointers equal.
- Push = `in_valid` && (!full || pop) && state != DONE. Pop = `out_valid` && `out_ready`.
- Simultaneous push+pop: both take effect, `count` unchanged; when full, push+pop is legal.
- `in_valid` while full with no pop: value dropped, pointers unchanged, drop event raised.
- `out_data` = mem[rd_ptr low bits], show-ahead; undefined-but-stable when empty; `out_valid` = !empty.
- `stall` = (`count` ≥ DEPTH − AF_MARGIN), combinational from registered `count`.
- Pointer wrap: low bits wrap modulo DEPTH, wrap bit toggles.
- State machine (2-bit): RUN → DRAIN when `prog_halt`=1 sampled; DRAIN → DONE when empty, no push this cycle and `in_valid`=0; DONE held until `rst`. DRAIN still accepts pushes; DONE ignores `in_valid` (not counted as drop). `done` = (state == DONE), registered.
- Reset (`rst`=1 at an edge): pointers 0, `count` 0, `out_valid` 0, `stall` 0, `done` 0, `overflow` 0, state RUN. Reset mid-drain discards contents.

## Timing
- Push at edge N → `out_valid`=1 and `out_data` valid from cycle after N (1-cycle latency).
- Pop at edge N → next entry visible after N; back-to-back pops at 1 value/cycle.
- `stall` rises the cycle after the push that reaches threshold; AF_MARGIN covers the 2-cycle fetch/decode depth.
- `done` rises one cycle after the edge at which FIFO is empty in DRAIN.

## Configuration
- `OUT_BUF_OVERFLOW_FLAG_EN` defined: `overflow` sets on first drop, stays 1 until `rst`.
- Undefined: drop logic unchanged, `overflow` tied 0, flag register not built.

## Structure
- Shared package/header: state encodings (ST_RUN, ST_DRAIN, ST_DONE), DATA_W=3 constant alongside existing opcode/select defines.
- One natural sub-module: `out_buf_mem` (storage array, synchronous write, asynchronous read); pointers, count, stall and FSM in `output_buffer`.

## Test plan
- Reset then push 5,2,7 with `out_ready`=1 → `out_data` 5,2,7 on consecutive cycles, each one cycle after push; `count` ≤1.
- `out_ready`=0, push 6 values (DEPTH=8) → `stall`=1 after 6th push, `count`=6; then ready=1 → drains in order, `stall` falls at count 5.
- Fill to 8, push 3 with no pop → dropped, `count`=8, `overflow`=1 (macro on) / 0 (off); push+pop when full → accepted, count stays 8.
- Push 12 values with interleaved pops → pointer wrap correct, output order preserved.
- `prog_halt`=1 with 3 queued, then one more push in DRAIN → all 4 drained, `done`=1 one cycle after empty; later `in_valid` ignored.
- Assert `rst` with 4 queued in DRAIN → next cycle `count`=0, `out_valid`=0, `done`=0, state RUN.
